mem_seq_control: RTL
====================

MEM_SEQ_CONTROL -- requirements
Module: mem_seq_control

Interface
REQ-001 The block SHALL have parameter INT_BEATS, default 2, memory beats for an interrupt context push.
REQ-002 The block SHALL have parameter CALL_BEATS, default 2, memory beats for a call return-address push.
REQ-003 The block SHALL have parameter RET_BEATS, default 2, memory beats for a return pop.
REQ-004 The block SHALL have parameter RTI_BEATS, default 3, memory beats for an RTI pop (PC plus flags).
REQ-005 The block SHALL have parameter CNT_W, default 2, beat counter width; every *_BEATS SHALL lie in 1..2**CNT_W, and elaboration SHALL fail otherwise.
REQ-006 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-007 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have ports int, rti, ret and call, each input, 1, level requests from the memory stage.
REQ-009 The block SHALL have port extend, output, 1, the pipeline stall request.
REQ-010 The block SHALL have port beat, output, CNT_W, the current beat index used as the stack-address word offset.
REQ-011 The block SHALL have port busy, output, 1, high while a multi-beat operation is in progress.
REQ-012 The block SHALL have ports jumpInt, jumpCall, jumpRet and jumpRti, each output, 1, one-cycle completion pulses.
REQ-013 The block SHALL have port flagRestore, output, 1, asserted together with jumpRti.

Function
REQ-014 The FSM SHALL have states IDLE, INT, CALL, RET and RTI, held in a registered state register plus a CNT_W-bit counter cnt.
REQ-015 In IDLE, the effective request SHALL be selected with fixed priority (int OR int_pending) > rti > ret > call.
REQ-016 Requests that lose arbitration SHALL NOT be latched; the requester keeps them asserted.
REQ-017 In the IDLE cycle where a request is selected, that cycle SHALL be beat 0 of the operation, with beat=0.
REQ-018 For an operation of N beats, beat k SHALL satisfy: extend=1 for k<N-1; extend=0 and the matching jump pulse=1 for k=N-1.
REQ-019 With N=1, the jump pulse SHALL occur in the request cycle, extend SHALL never assert, and the state SHALL remain IDLE.
REQ-020 For N>1, the clock edge ending beat 0 SHALL move to the operation state with cnt=1, and beat SHALL equal cnt while in an operation state.
REQ-021 The edge ending beat N-1 SHALL return to IDLE with cnt=0, and the counter SHALL never wrap.
REQ-022 busy SHALL equal (state != IDLE), registered.
REQ-023 At most one jump* output SHALL be high in any cycle, and all jump* outputs and flagRestore SHALL be 0 in IDLE with no request.
REQ-024 An int asserted while in state CALL, RET or RTI SHALL set int_pending.
REQ-025 After an operation where int_pending was set, the next IDLE cycle SHALL start INT at beat 0.
REQ-026 int_pending SHALL be cleared on the edge leaving the INT beat 0 cycle, or at the end of that cycle when INT_BEATS=1.
REQ-027 int asserted while in state INT SHALL be ignored; if int is still high when INT completes, a new INT SHALL start in the following IDLE cycle.
REQ-028 Request inputs SHALL have no effect on the current operation once it has left IDLE.

Reset
REQ-029 While rst=0, the state SHALL be IDLE, cnt=0 and int_pending=0, applied asynchronously and immediately.
REQ-030 While rst=0, the outputs SHALL be extend=0, beat=0, busy=0, all jump*=0 and flagRestore=0, regardless of the request inputs.
REQ-031 A reset asserted mid-operation SHALL abort it with no jump pulse.
REQ-032 After rst rises, the first rising edge SHALL resume normal IDLE operation.

Verification
REQ-033 Defaults, ret high for 2 cycles -> c0: extend=1 beat=0; c1: extend=0 beat=1 jumpRet=1 busy=1; c2: idle, all 0.
REQ-034 Defaults, rti held -> extend=1,1,0 over c0..c2; jumpRti=1 and flagRestore=1 only at c2 with beat=2.
REQ-035 int and ret asserted together in IDLE -> INT selected, jumpInt at c1, jumpRet never pulses while ret is low after c1.
REQ-036 ret at c0, int pulsed at c1 -> jumpRet at c1; INT beat 0 with extend=1 at c2; jumpInt at c3.
REQ-037 rti started, rst driven low during beat 1 -> all outputs 0 in the same cycle, no jumpRti; after release, idle with busy=0.
REQ-038 CALL_BEATS=1, call high for one cycle -> jumpCall=1 in the same cycle, extend=0, busy stays 0.

Source files
------------

// File: rtl/mem_seq_control.sv
// Memory-stage sequencer for multi-beat stack operations: interrupt context
// push, call return-address push, return pop and RTI pop. It stalls the
// pipeline with extend_o and presents the word offset on beat_o. When an
// operation finishes, it pulses the matching jump output for one cycle.
// Beat 0 of every operation is the IDLE cycle in which the request is
// selected, so the outputs are a Mealy function of the inputs in IDLE.
module mem_seq_control #(
  parameter int INT_BEATS  = 2,
  parameter int CALL_BEATS = 2,
  parameter int RET_BEATS  = 2,
  parameter int RTI_BEATS  = 3,
  parameter int CNT_W      = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,          // asynchronous, active low
  input  logic             int_i,
  input  logic             rti_i,
  input  logic             ret_i,
  input  logic             call_i,
  output logic             extend_o,
  output logic [CNT_W-1:0] beat_o,
  output logic             busy_o,
  output logic             jump_int_o,
  output logic             jump_call_o,
  output logic             jump_ret_o,
  output logic             jump_rti_o,
  output logic             flag_restore_o
);

  localparam int MAX_BEATS = 2 ** CNT_W;

  // Reject beat counts that the counter cannot index.
  if (INT_BEATS  < 1 || INT_BEATS  > MAX_BEATS ||
      CALL_BEATS < 1 || CALL_BEATS > MAX_BEATS ||
      RET_BEATS  < 1 || RET_BEATS  > MAX_BEATS ||
      RTI_BEATS  < 1 || RTI_BEATS  > MAX_BEATS) begin : g_bad_beats
    $error("mem_seq_control: every *_BEATS must lie in 1..2**CNT_W");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_INT,
    S_CALL,
    S_RET,
    S_RTI
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             int_pend_q, int_pend_d;
  logic             busy_q;

  state_e           op;        // operation owning the current beat
  logic [CNT_W-1:0] cur_beat;
  logic             extend;
  logic             done;      // current beat is the last of op

  // Index of the final beat for each operation.
  function automatic logic [CNT_W-1:0] last_beat(input state_e s);
    case (s)
      S_INT:   return CNT_W'(INT_BEATS - 1);
      S_CALL:  return CNT_W'(CALL_BEATS - 1);
      S_RET:   return CNT_W'(RET_BEATS - 1);
      S_RTI:   return CNT_W'(RTI_BEATS - 1);
      default: return '0;
    endcase
  endfunction

  // Arbitration in IDLE, beat sequencing in the operation states.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned, which would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    int_pend_d = int_pend_q;
    op         = S_IDLE;
    cur_beat   = '0;
    extend     = 1'b0;
    done       = 1'b0;

    if (state_q == S_IDLE) begin
      // Losing requests are not remembered; requesters hold them.
      if (int_i || int_pend_q) op = S_INT;
      else if (rti_i)          op = S_RTI;
      else if (ret_i)          op = S_RET;
      else if (call_i)         op = S_CALL;

      if (op != S_IDLE) begin
        // A pending interrupt is consumed once its INT has begun.
        if (op == S_INT) int_pend_d = 1'b0;
        if (last_beat(op) == '0) begin
          done = 1'b1;
        end else begin
          extend  = 1'b1;
          state_d = op;
          cnt_d   = CNT_W'(1);
        end
      end
    end else begin
      op       = state_q;
      cur_beat = cnt_q;
      // An interrupt arriving during INT itself is not remembered.
      if (int_i && state_q != S_INT) int_pend_d = 1'b1;
      if (cnt_q == last_beat(state_q)) begin
        done    = 1'b1;
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        extend = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  // State, beat counter, pending interrupt and busy flag registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      int_pend_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      int_pend_q <= int_pend_d;
      busy_q     <= (state_d != S_IDLE);
    end
  end

  // NOTE: the IDLE-cycle outputs follow the request inputs directly, so reset must also gate them to hold them low.
  assign extend_o       = rst_i & extend;
  assign beat_o         = rst_i ? cur_beat : '0;
  assign busy_o         = busy_q;
  assign jump_int_o     = rst_i & done & (op == S_INT);
  assign jump_call_o    = rst_i & done & (op == S_CALL);
  assign jump_ret_o     = rst_i & done & (op == S_RET);
  assign jump_rti_o     = rst_i & done & (op == S_RTI);
  assign flag_restore_o = jump_rti_o;

endmodule
